// File: rtl/decoder_seq.sv
// Registered N-to-2^N one-hot decoder with OFF / DIRECT / SCAN / HOLD operating modes.
// All outputs are registered; the mode is sampled into the state and acted on one edge later.
module decoder_seq #(
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned SCAN_DIV   = 4,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic [1:0]            i_mode,
  input  logic [SEL_W-1:0]      i_sel,
  input  logic                  i_in_valid,
  output logic [(2**SEL_W)-1:0] o_out,
  output logic [SEL_W-1:0]      o_out_idx,
  output logic                  o_out_valid,
  output logic                  o_step
);

  localparam int unsigned OUT_W = 2**SEL_W;
  localparam int unsigned CNT_W = $clog2(SCAN_DIV + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [OUT_W-1:0] OUT_IDLE = {OUT_W{ACTIVE_LOW != 0}};

  typedef enum logic [1:0] {
    StOff    = 2'b00,
    StDirect = 2'b01,
    StScan   = 2'b10,
    StHold   = 2'b11
  } state_e;

  state_e           r_state;
  logic [OUT_W-1:0] r_out;
  logic [SEL_W-1:0] r_out_idx;
  logic             r_out_valid;
  logic             r_step;
  logic [CNT_W-1:0] r_div_cnt;

  logic [SEL_W-1:0] w_idx_next;
  logic             w_div_last;

  // Index arithmetic wraps naturally modulo 2**SEL_W.
  assign w_idx_next = r_out_idx + 1'b1;
  assign w_div_last = (r_div_cnt == DIV_LAST);

  function automatic logic [OUT_W-1:0] f_drive(input logic [SEL_W-1:0] idx);
    logic [OUT_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v ^ OUT_IDLE;
  endfunction

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      r_state     <= StOff;
      r_out       <= OUT_IDLE;
      r_out_idx   <= '0;
      r_out_valid <= 1'b0;
      r_step      <= 1'b0;
      r_div_cnt   <= '0;
    end else begin
      r_state <= state_e'(i_mode);
      r_step  <= 1'b0;
      unique case (r_state)
        StOff: begin
          r_out       <= OUT_IDLE;
          r_out_valid <= 1'b0;
          r_div_cnt   <= '0;
        end
        StDirect: begin
          r_div_cnt <= '0;
          if (i_in_valid) begin
            r_out_idx   <= i_sel;
            r_out       <= f_drive(i_sel);
            r_out_valid <= 1'b1;
          end
        end
        StScan: begin
          r_out_valid <= 1'b1;
          if (w_div_last) begin
            r_div_cnt <= '0;
            r_out_idx <= w_idx_next;
            r_out     <= f_drive(w_idx_next);
            r_step    <= 1'b1;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
            r_out     <= f_drive(r_out_idx);
          end
        end
        StHold: begin
          // Everything frozen, including the divider, so SCAN resumes mid-count.
        end
      endcase
    end
  end

  assign o_out       = r_out;
  assign o_out_idx   = r_out_idx;
  assign o_out_valid = r_out_valid;
  assign o_step      = r_step;

endmodule
